// File: rtl/tlc_intersection_sched_if.sv
// rtl/tlc_intersection_sched_if.sv - register write handshake between master and scheduler
interface tlc_intersection_sched_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output addr, output data, output valid, input ready);
  modport slave  (input addr, input data, input valid, output ready);
endinterface

// File: rtl/tlc_intersection_sched.sv
// rtl/tlc_intersection_sched.sv - round-robin four-approach green scheduler with timed phases
module tlc_intersection_sched #(
  parameter int CLK_PER_SEC = 1000,
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  tlc_intersection_sched_if.slave  regs,
  input  logic [3:0]               req,
  output logic [7:0]               light,
  output logic [1:0]               grant_id,
  output logic [1:0]               phase
);
  localparam logic [1:0] ST_ALLRED = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0]         PRESC_TC = PW'(CLK_PER_SEC - 1);
  localparam logic [DATA_WIDTH-1:0] E_MAX    = '1;
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

  logic [1:0]            state, state_n, grant_n, rr, pick;
  logic [PW-1:0]         presc;
  logic [DATA_WIDTH-1:0] elapsed, elapsed_n;
  logic [DATA_WIDTH-1:0] reg_gmin, reg_gmax, reg_yel, reg_allred;
  logic [DATA_WIDTH-1:0] sh_gmin, sh_gmax, sh_yel, sh_allred;
  logic [DATA_WIDTH-1:0] gmin_e, gmax_raw, gmax_e, yel_e, allred_e;
  logic [3:0]            pending, reqs, grant_mask, others, green_mask, entry_mask;
  logic                  tc, pick_valid, enter, wr_ok;

  assign tc = (presc == PRESC_TC);
  // Compare against the count as it will stand after this edge, so a T-second
  // phase spans exactly T*CLK_PER_SEC cycles including the registered transition.
  assign elapsed_n = (tc && elapsed != E_MAX) ? elapsed + ONE : elapsed;

  assign gmin_e   = (sh_gmin == '0) ? ONE : sh_gmin;
  assign gmax_raw = (sh_gmax == '0) ? ONE : sh_gmax;
  assign gmax_e   = (gmax_raw < gmin_e) ? gmin_e : gmax_raw;
  assign yel_e    = (sh_yel == '0) ? ONE : sh_yel;
  assign allred_e = (sh_allred == '0) ? ONE : sh_allred;

  assign reqs       = pending | req;
  assign grant_mask = 4'b0001 << grant_id;
  assign others     = reqs & ~grant_mask;
  assign green_mask = (state == ST_GREEN) ? grant_mask : 4'b0000;
  assign entry_mask = (state == ST_ALLRED && enter) ? (4'b0001 << pick) : 4'b0000;
  assign wr_ok      = (32'(regs.addr) < 32'd4);

  // Nearest requester after the pointer wins; the pointer itself is checked last.
  always_comb begin
    pick       = rr;
    pick_valid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (reqs[rr + 2'(k)]) begin
        pick       = rr + 2'(k);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    enter   = 1'b0;
    case (state)
      ST_ALLRED: if (elapsed_n >= allred_e && pick_valid) begin
        state_n = ST_GREEN;
        grant_n = pick;
        enter   = 1'b1;
      end
      ST_GREEN: if (others != 4'b0000 &&
                    ((elapsed_n >= gmin_e && !req[grant_id]) || elapsed_n >= gmax_e)) begin
        state_n = ST_YELLOW;
        enter   = 1'b1;
      end
      ST_YELLOW: if (elapsed_n >= yel_e) begin
        state_n = ST_ALLRED;
        enter   = 1'b1;
      end
      default: begin
        state_n = ST_ALLRED;
        enter   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_ALLRED;
      grant_id   <= 2'd0;
      rr         <= 2'd3;
      pending    <= 4'b0000;
      presc      <= '0;
      elapsed    <= '0;
      reg_gmin   <= DATA_WIDTH'(5);
      reg_gmax   <= DATA_WIDTH'(20);
      reg_yel    <= DATA_WIDTH'(3);
      reg_allred <= DATA_WIDTH'(1);
      sh_gmin    <= DATA_WIDTH'(5);
      sh_gmax    <= DATA_WIDTH'(20);
      sh_yel     <= DATA_WIDTH'(3);
      sh_allred  <= DATA_WIDTH'(1);
      regs.ready <= 1'b0;
    end else begin
      state    <= state_n;
      grant_id <= grant_n;
      pending  <= reqs & ~green_mask & ~entry_mask;
      if (state == ST_ALLRED && enter) rr <= pick;
      if (enter) begin
        presc     <= '0;
        elapsed   <= '0;
        sh_gmin   <= reg_gmin;
        sh_gmax   <= reg_gmax;
        sh_yel    <= reg_yel;
        sh_allred <= reg_allred;
      end else begin
        presc   <= tc ? '0 : presc + PW'(1);
        elapsed <= elapsed_n;
      end
      regs.ready <= regs.valid && wr_ok;
      if (regs.valid && wr_ok) begin
        case (regs.addr[1:0])
          2'd0:    reg_gmin   <= regs.data;
          2'd1:    reg_gmax   <= regs.data;
          2'd2:    reg_yel    <= regs.data;
          default: reg_allred <= regs.data;
        endcase
      end
    end
  end

  always_comb begin
    light = 8'h55;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == grant_id && state == ST_GREEN)  light[2*i +: 2] = 2'b11;
      if (2'(i) == grant_id && state == ST_YELLOW) light[2*i +: 2] = 2'b10;
    end
  end

  assign phase = state;
endmodule

// File: tb/tb_tlc_intersection_sched.sv
// tb/tb_tlc_intersection_sched.sv - scoreboard bench for tlc_intersection_sched
module tb_tlc_intersection_sched;
  localparam int C = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] light;
  logic [1:0] grant_id;
  logic [1:0] phase;

  tlc_intersection_sched_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) rif ();

  tlc_intersection_sched #(.CLK_PER_SEC(C), .ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .regs(rif), .req(req),
    .light(light), .grant_id(grant_id), .phase(phase)
  );

  typedef struct {
    int         cyc;
    logic [7:0] light;
    logic [1:0] grant;
    logic [1:0] phase;
  } exp_t;

  exp_t exp_q[$];
  int   rdy_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   in_reset = 1;
  logic [11:0] prev;

  // Reference model: phase durations tracked as whole cycles spent in the phase.
  int         m_phase, m_grant, m_rr, m_cyc;
  int         m_reg[4];
  int         m_sh[4];
  logic [3:0] m_pend;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lamp(int p, int g);
    logic [7:0] l;
    l = 8'h55;
    if (p == 1) l[2*g +: 2] = 2'b11;
    else if (p == 2) l[2*g +: 2] = 2'b10;
    return l;
  endfunction

  function automatic int secs(int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_grant = 0; m_rr = 3; m_cyc = 0; m_pend = 4'b0000;
    m_reg[0] = 5; m_reg[1] = 20; m_reg[2] = 3; m_reg[3] = 1;
    for (int i = 0; i < 4; i++) m_sh[i] = m_reg[i];
  endtask

  task automatic step(input logic [3:0] r, input logic v, input logic [2:0] a, input logic [7:0] d);
    logic [3:0] reqs, other;
    int nxt_p, nxt_g, done, gmin, gmax;
    bit entered;
    req = r; rif.valid = v; rif.addr = a; rif.data = d;
    reqs = m_pend | r;
    other = reqs & ~(4'b0001 << m_grant);
    done = m_cyc + 1;
    gmin = secs(m_sh[0]);
    gmax = secs(m_sh[1]);
    if (gmax < gmin) gmax = gmin;
    nxt_p = m_phase; nxt_g = m_grant; entered = 0;
    if (m_phase == 0) begin
      if (done >= secs(m_sh[3]) * C && reqs != 4'b0000) begin
        for (int k = 4; k >= 1; k--)
          if (reqs[(m_rr + k) % 4]) nxt_g = (m_rr + k) % 4;
        nxt_p = 1; entered = 1;
      end
    end else if (m_phase == 1) begin
      if (other != 4'b0000 && ((done >= gmin * C && !r[m_grant]) || done >= gmax * C)) begin
        nxt_p = 2; entered = 1;
      end
    end else begin
      if (done >= secs(m_sh[2]) * C) begin
        nxt_p = 0; entered = 1;
      end
    end
    m_pend = reqs;
    if (m_phase == 1) m_pend[m_grant] = 1'b0;
    if (m_phase == 0 && entered) begin
      m_pend[nxt_g] = 1'b0;
      m_rr = nxt_g;
    end
    if (entered) begin
      for (int i = 0; i < 4; i++) m_sh[i] = m_reg[i];
      m_cyc = 0;
      exp_q.push_back('{cyc + 1, lamp(nxt_p, nxt_g), 2'(nxt_g), 2'(nxt_p)});
    end else begin
      m_cyc = m_cyc + 1;
    end
    if (v && a < 3'd4) begin
      m_reg[a[1:0]] = int'(d);
      rdy_q.push_back(cyc + 1);
    end
    m_phase = nxt_p; m_grant = nxt_g;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Called at posedge+1; leaves reset released with the model aligned to cycle 0.
  task automatic do_reset();
    req = 4'b0000; rif.valid = 1'b0;
    in_reset = 1;
    rst = 1'b0;
    #1;
    chk("rst_light", light, 8'h55);
    chk("rst_phase", {6'd0, phase}, 8'd0);
    chk("rst_grant", {6'd0, grant_id}, 8'd0);
    chk("rst_ready", {7'd0, rif.ready}, 8'd0);
    exp_q.delete(); rdy_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    in_reset = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!in_reset && {light, grant_id, phase} != prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d light=%h grant=%0d phase=%0d", cyc, light, grant_id, phase);
      end else begin
        e = exp_q.pop_front();
        if (e.light !== light || e.grant !== grant_id || e.phase !== phase || e.cyc != cyc) begin
          errors++;
          $display("FAIL transition got cyc=%0d light=%h grant=%0d phase=%0d want cyc=%0d light=%h grant=%0d phase=%0d",
                   cyc, light, grant_id, phase, e.cyc, e.light, e.grant, e.phase);
        end
      end
    end
    if (!in_reset && rif.ready === 1'b1) begin
      checks++;
      if (rdy_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready cyc=%0d got 1 want 0", cyc);
      end else if (rdy_q.pop_front() != cyc) begin
        errors++;
        $display("FAIL ready_timing cyc=%0d ready out of order", cyc);
      end
    end
    prev = {light, grant_id, phase};
  end

  initial begin
    logic [3:0] lv, pulse;
    int n;
    rst = 1'b0; req = 4'b0000;
    rif.valid = 1'b0; rif.addr = 3'd0; rif.data = 8'd0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    repeat (200) step(4'b0000, 1'b0, 3'd0, 8'd0);
    chk("idle_light", light, 8'h55);
    chk("idle_phase", {6'd0, phase}, 8'd0);
    chk("idle_grant", {6'd0, grant_id}, 8'd0);

    do_reset();
    repeat (10) step(4'b0000, 1'b0, 3'd0, 8'd0);
    step(4'b0100, 1'b0, 3'd0, 8'd0);
    chk("first_green", light, 8'b01110101);
    step(4'b0001, 1'b0, 3'd0, 8'd0);
    repeat (60) step(4'b0000, 1'b0, 3'd0, 8'd0);

    do_reset();
    repeat (10) step(4'b0000, 1'b0, 3'd0, 8'd0);
    step(4'b0100, 1'b0, 3'd0, 8'd0);
    step(4'b0110, 1'b0, 3'd0, 8'd0);
    repeat (100) step(4'b0100, 1'b0, 3'd0, 8'd0);
    repeat (80) step(4'b0000, 1'b0, 3'd0, 8'd0);

    do_reset();
    repeat (5) step(4'b0000, 1'b0, 3'd0, 8'd0);
    step(4'b0010, 1'b0, 3'd0, 8'd0);
    step(4'b1111, 1'b0, 3'd0, 8'd0);
    repeat (200) step(4'b0000, 1'b0, 3'd0, 8'd0);

    step(4'b0000, 1'b1, 3'd2, 8'd1);
    step(4'b0000, 1'b1, 3'd5, 8'd0);
    repeat (5) step(4'b0000, 1'b0, 3'd0, 8'd0);
    step(4'b1000, 1'b0, 3'd0, 8'd0);
    n = 0;
    while (!(m_phase == 2 && m_cyc == 2) && n < 200) begin
      step(4'b0000, 1'b0, 3'd0, 8'd0);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL yellow_wait got %0d cycles want <200", n);
    end
    do_reset();

    lv = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 39) == 0) lv[b] = ~lv[b];
      pulse = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      step(lv | pulse, ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 6)));
    end
    repeat (3) step(4'b0000, 1'b0, 3'd0, 8'd0);

    chk("exp_q_drained", 8'(exp_q.size()), 8'd0);
    chk("rdy_q_drained", 8'(rdy_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlc_intersection_sched.md
Name: tlc_intersection_sched

Overview:
Four-approach intersection scheduler that shares the single right-of-way (green) among four approaches. Each approach raises vehicle/pedestrian requests; the block grants green in round-robin order and sequences GREEN -> YELLOW -> ALLRED between grants. Phase durations live in seconds-valued registers that a master programs over the team's addr/data/valid/ready register handshake. Sits above the per-approach lamp drivers; its light bus uses the team's state encoding.

Parameters:
CLK_PER_SEC, 1000, integer clock cycles per second (prescaler terminal count)
ADDR_WIDTH, 3, register address bus width
DATA_WIDTH, 8, register data width (seconds, unsigned)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
addr  in  ADDR_WIDTH  register address
data  in  DATA_WIDTH  register write data
valid  in  1  master write strobe
ready  out  1  write accepted
req  in  4  per-approach request, pulse or level
light  out  8  lamp state, approach i on light[2i+1:2i]: RESET=00, RED=01, YELLOW=10, GREEN=11
grant_id  out  2  approach currently (or last) holding right-of-way
phase  out  2  0=ALLRED, 1=GREEN, 2=YELLOW

Behaviour:
- Reset (rst=0, asynchronous): light=8'b01010101, grant_id=0, phase=ALLRED, ready=0, pending=0, rr pointer=3. Registers: GMIN=5, GMAX=20, YEL=3, ALLRED=1. Prescaler and elapsed counter=0.
- Registers: addr0 GMIN, addr1 GMAX, addr2 YEL, addr3 ALLRED. A valid cycle with addr<=3 writes the register; ready=1 on the following cycle, for one cycle per valid cycle. A valid cycle with addr>3 writes nothing; ready stays 0. ready=0 whenever valid was 0 on the previous cycle.
- Register values are captured into shadow copies at each phase entry; writes take effect from the next phase entry.
- Shadow value 0 is treated as 1. If GMAX<GMIN, GMAX is treated as GMIN.
- Timing: prescaler counts 0..CLK_PER_SEC-1; elapsed seconds increments on terminal count; both cleared on every phase entry. A phase of T seconds lasts exactly T*CLK_PER_SEC cycles. elapsed saturates at 255.
- pending[i] sets on req[i]=1 except while approach i is green. pending[i] clears on entry to GREEN for approach i. Every decision uses pending|req, so a same-cycle request counts.
- FSM:
  - ALLRED: all lamps RED. Once elapsed>=ALLRED and any request exists, go to GREEN for the first requesting approach after the rr pointer (wrapping). Update grant_id and set the rr pointer to it. With no requests, rest in ALLRED indefinitely.
  - GREEN(g): light[g]=GREEN, others RED. Leave to YELLOW when another approach has a request and either (elapsed>=GMIN and req[g]=0) or elapsed>=GMAX. With no other request, rest in GREEN indefinitely (GMAX is not enforced).
  - YELLOW(g): light[g]=YELLOW. When elapsed>=YEL, go to ALLRED.
- Each transition is registered: lamps change on the clock edge after the condition holds. Exactly one approach is ever non-RED.
- Reset mid-phase returns all outputs to reset values immediately. After release, ALLRED restarts from 0; the rr pointer returns to 3.

Test Plan:
1. CLK_PER_SEC=4. Release reset, req=0 for 200 cycles -> light=8'h55, phase=0, grant_id=0 throughout; ready=0.
2. From rest, pulse req[2] at cycle 10 after release -> light=8'b01110101 on cycle 11, grant_id=2, phase=1.
3. Approach 2 green, req[2]=0, pulse req[0] -> GREEN lasts 20 cycles (GMIN 5s), YELLOW 12 cycles, ALLRED 4 cycles, then light[1:0]=11 and grant_id=0.
4. Approach 2 green, req[2] held 1, req[1] pending -> green holds 80 cycles (GMAX 20s), then YELLOW.
5. Approach 1 green, req=4'b1111 pulsed -> subsequent greens in order 2,3,0; approach 1 is not re-served until after 0.
6. Write addr2 data 1 during GREEN -> ready=1 next cycle, current GREEN unchanged, next YELLOW lasts 4 cycles. Write addr5 -> ready stays 0, no register changes. Drop rst mid-YELLOW -> light=8'h55 without waiting for a clock edge.
